// File: rtl/tone_envelope.sv
// tone_envelope: ADSR-style envelope generator that gates a square-wave tone
// through an 8-bit PWM whose duty follows the envelope level.
//
// Ports:
//   clk_i    - single clock, all state updates on rising edge
//   rst_n    - asynchronous active-low reset
//   tone_i   - square-wave tone, synchronous to clk_i
//   gate_i   - note gate, high while the note is held
//   audio_o  - registered envelope-modulated PWM audio
//   level_o  - current envelope level (0..255)
//   state_o  - envelope state: 0 idle, 1 attack, 2 decay, 3 sustain, 4 release
//   busy_o   - high whenever state_o is not idle
module tone_envelope #(
  parameter int unsigned PRESC        = 1000,
  parameter int unsigned ATTACK_STEP  = 16,
  parameter int unsigned DECAY_STEP   = 2,
  parameter int unsigned SUSTAIN_LVL  = 96,
  parameter int unsigned RELEASE_STEP = 4
) (
  input  logic       clk_i,
  input  logic       rst_n,
  input  logic       tone_i,
  input  logic       gate_i,
  output logic       audio_o,
  output logic [7:0] level_o,
  output logic [2:0] state_o,
  output logic       busy_o
);

  localparam int unsigned PW = (PRESC > 1) ? $clog2(PRESC) : 1;
  localparam logic [PW-1:0] PrescMax = PW'(PRESC - 1);

  localparam logic [8:0] AttStep = 9'(ATTACK_STEP);
  localparam logic [8:0] DecStep = 9'(DECAY_STEP);
  localparam logic [8:0] RelStep = 9'(RELEASE_STEP);
  localparam logic [8:0] SusLvl  = 9'(SUSTAIN_LVL);

  typedef enum logic [2:0] {
    StIdle    = 3'd0,
    StAttack  = 3'd1,
    StDecay   = 3'd2,
    StSustain = 3'd3,
    StRelease = 3'd4
  } state_e;

  state_e        r_state;
  logic [7:0]    r_level;
  logic          r_gate;
  logic [PW-1:0] r_presc;
  logic [7:0]    r_pwm;
  logic          r_audio;

  logic          w_rise;
  logic          w_fall;
  logic          w_tick;
  logic [8:0]    w_att_sum;
  logic          w_dec_floor;
  logic          w_rel_floor;
  logic [7:0]    w_dec_lvl;
  logic [7:0]    w_rel_lvl;

  assign w_rise    = gate_i & ~r_gate;
  assign w_fall    = ~gate_i & r_gate;
  assign w_tick    = (r_presc == PrescMax);
  assign w_att_sum = {1'b0, r_level} + AttStep;

  // Saturation tests are done before subtracting so the 8-bit differences
  // below are only used when they cannot underflow past the floor.
  assign w_dec_floor = ({1'b0, r_level} <= (SusLvl + DecStep));
  assign w_rel_floor = ({1'b0, r_level} <= RelStep);
  assign w_dec_lvl   = r_level - DecStep[7:0];
  assign w_rel_lvl   = r_level - RelStep[7:0];

  // Envelope FSM, level and prescaler.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= StIdle;
      r_level <= 8'd0;
      r_gate  <= 1'b0;
      r_presc <= '0;
    end else begin
      r_gate <= gate_i;
      if (w_rise) begin
        // Retrigger keeps the current level and restarts the tick phase.
        r_state <= StAttack;
        r_presc <= '0;
      end else begin
        r_presc <= w_tick ? '0 : r_presc + 1'b1;
        if (w_fall) begin
          // Any gate edge swallows a coincident tick.
          if (r_state inside {StAttack, StDecay, StSustain}) begin
            r_state <= StRelease;
          end
        end else if (w_tick) begin
          case (r_state)
            StAttack: begin
              if (w_att_sum >= 9'd255) begin
                r_level <= 8'd255;
                r_state <= StDecay;
              end else begin
                r_level <= w_att_sum[7:0];
              end
            end
            StDecay: begin
              if (w_dec_floor) begin
                r_level <= SusLvl[7:0];
                r_state <= StSustain;
              end else begin
                r_level <= w_dec_lvl;
              end
            end
            StRelease: begin
              if (w_rel_floor) begin
                r_level <= 8'd0;
                r_state <= StIdle;
              end else begin
                r_level <= w_rel_lvl;
              end
            end
            default: ;
          endcase
        end
      end
    end
  end

  // Free-running PWM; level 255 still leaves one low slot per period.
  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      r_pwm   <= 8'd0;
      r_audio <= 1'b0;
    end else begin
      r_pwm   <= r_pwm + 8'd1;
      r_audio <= tone_i & (r_pwm < r_level);
    end
  end

  assign audio_o = r_audio;
  assign level_o = r_level;
  assign state_o = r_state;
  assign busy_o  = (r_state != StIdle);

endmodule

// File: tb/tb_tone_envelope.sv
// Self-checking bench for tone_envelope: directed table of gate sequences with
// constant expectations, PWM duty and async-reset checks, then randomized gate
// and tone stimulus compared against an arithmetic envelope model.
module tb_tone_envelope;

  localparam int P  = 4;
  localparam int A  = 64;
  localparam int D  = 32;
  localparam int S  = 128;
  localparam int R  = 64;

  logic       clk_i = 1'b0;
  logic       rst_n = 1'b0;
  logic       tone_i = 1'b0;
  logic       gate_i = 1'b0;
  logic       audio_o;
  logic [7:0] level_o;
  logic [2:0] state_o;
  logic       busy_o;

  tone_envelope #(
    .PRESC       (P),
    .ATTACK_STEP (A),
    .DECAY_STEP  (D),
    .SUSTAIN_LVL (S),
    .RELEASE_STEP(R)
  ) dut (
    .clk_i  (clk_i),
    .rst_n  (rst_n),
    .tone_i (tone_i),
    .gate_i (gate_i),
    .audio_o(audio_o),
    .level_o(level_o),
    .state_o(state_o),
    .busy_o (busy_o)
  );

  always #5 clk_i = ~clk_i;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: envelope described by its rules, one call per clock edge.
  int m_state, m_level, m_presc, m_pwm, m_audio;
  bit m_prev;

  function automatic void model_reset();
    m_state = 0; m_level = 0; m_presc = 0; m_pwm = 0; m_audio = 0; m_prev = 0;
  endfunction

  function automatic void model_step(input bit g, input bit t);
    bit rise, fall, tick;
    rise = g && !m_prev;
    fall = !g && m_prev;
    tick = (m_presc == P - 1);
    m_audio = (t && (m_pwm < m_level)) ? 1 : 0;
    m_pwm = (m_pwm + 1) % 256;
    if (rise) begin
      m_state = 1;
      m_presc = 0;
    end else begin
      m_presc = (m_presc + 1) % P;
      if (fall) begin
        if (m_state >= 1 && m_state <= 3) m_state = 4;
      end else if (tick) begin
        if (m_state == 1) begin
          m_level = m_level + A;
          if (m_level >= 255) begin m_level = 255; m_state = 2; end
        end else if (m_state == 2) begin
          m_level = m_level - D;
          if (m_level <= S) begin m_level = S; m_state = 3; end
        end else if (m_state == 4) begin
          m_level = m_level - R;
          if (m_level <= 0) begin m_level = 0; m_state = 0; end
        end
      end
    end
    m_prev = g;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40) $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Drive inputs, take one rising edge, leave time 1 unit after that edge.
  task automatic step(input bit g, input bit t);
    gate_i = g;
    tone_i = t;
    @(posedge clk_i);
    model_step(g, t);
    #1;
  endtask

  typedef struct {
    bit gate;
    int ncyc;
    int st;
    int lvl;
  } vec_t;

  vec_t tbl[$];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    bit g, t;

    // Relative to the rise edge: ticks land every 4 edges after it.
    tbl.push_back('{1'b0, 1, 0, 0});
    tbl.push_back('{1'b1, 1, 1, 0});
    tbl.push_back('{1'b1, 4, 1, 64});
    tbl.push_back('{1'b1, 4, 1, 128});
    tbl.push_back('{1'b1, 4, 1, 192});
    tbl.push_back('{1'b1, 3, 1, 192});
    tbl.push_back('{1'b1, 1, 2, 255});
    tbl.push_back('{1'b1, 4, 2, 223});
    tbl.push_back('{1'b1, 4, 2, 191});
    tbl.push_back('{1'b1, 4, 2, 159});
    tbl.push_back('{1'b1, 4, 3, 128});
    tbl.push_back('{1'b1, 8, 3, 128});
    tbl.push_back('{1'b0, 1, 4, 128});   // fall in sustain
    tbl.push_back('{1'b0, 2, 4, 128});
    tbl.push_back('{1'b0, 1, 4, 64});
    tbl.push_back('{1'b0, 3, 4, 64});
    tbl.push_back('{1'b0, 1, 0, 0});     // release done, busy drops
    tbl.push_back('{1'b1, 1, 1, 0});
    tbl.push_back('{1'b1, 4, 1, 64});
    tbl.push_back('{1'b1, 4, 1, 128});
    tbl.push_back('{1'b0, 1, 4, 128});   // fall in attack
    tbl.push_back('{1'b0, 1, 4, 128});
    tbl.push_back('{1'b1, 1, 1, 128});   // retrigger keeps level
    tbl.push_back('{1'b1, 3, 1, 128});
    tbl.push_back('{1'b1, 1, 1, 192});   // first tick 4 edges after rise
    tbl.push_back('{1'b1, 3, 1, 192});
    tbl.push_back('{1'b0, 1, 4, 192});   // fall in tick cycle: tick ignored
    tbl.push_back('{1'b0, 3, 4, 192});
    tbl.push_back('{1'b1, 1, 1, 192});   // rise in tick cycle: tick ignored
    tbl.push_back('{1'b1, 3, 1, 192});
    tbl.push_back('{1'b1, 1, 2, 255});   // prescaler restarted from 0

    model_reset();
    repeat (3) @(posedge clk_i);
    #1;
    chk("reset.state", int'(state_o), 0);
    chk("reset.level", int'(level_o), 0);
    chk("reset.busy", int'(busy_o), 0);
    chk("reset.audio", int'(audio_o), 0);
    rst_n = 1'b1;
    model_reset();

    foreach (tbl[i]) begin
      for (int k = 0; k < tbl[i].ncyc; k++) step(tbl[i].gate, 1'b0);
      chk($sformatf("tbl%0d.state", i), int'(state_o), tbl[i].st);
      chk($sformatf("tbl%0d.level", i), int'(level_o), tbl[i].lvl);
      chk($sformatf("tbl%0d.busy", i), int'(busy_o), (tbl[i].st != 0) ? 1 : 0);
    end

    // Duty at sustain level 128.
    repeat (20) step(1'b1, 1'b0);
    chk("duty128.state", int'(state_o), 3);
    chk("duty128.level", int'(level_o), 128);
    step(1'b1, 1'b1);
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      step(1'b1, 1'b1);
      if (audio_o) cnt++;
    end
    chk("duty128.high_cycles", cnt, 128);

    // Duty at level 0 after a full release.
    repeat (12) step(1'b0, 1'b1);
    chk("duty0.state", int'(state_o), 0);
    chk("duty0.level", int'(level_o), 0);
    cnt = 0;
    for (int k = 0; k < 256; k++) begin
      step(1'b0, 1'b1);
      if (audio_o) cnt++;
    end
    chk("duty0.high_cycles", cnt, 0);

    // Asynchronous reset in decay at level 191.
    repeat (25) step(1'b1, 1'b1);
    chk("areset.pre_state", int'(state_o), 2);
    chk("areset.pre_level", int'(level_o), 191);
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset.state", int'(state_o), 0);
    chk("areset.level", int'(level_o), 0);
    chk("areset.audio", int'(audio_o), 0);
    chk("areset.busy", int'(busy_o), 0);

    // Gate already high when reset releases counts as a rise.
    gate_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    rst_n = 1'b1;
    model_reset();
    step(1'b1, 1'b0);
    chk("rel_gate_high.state", int'(state_o), 1);
    chk("rel_gate_high.level", int'(level_o), 0);

    // Randomized gate/tone against the model.
    g = 1'b1;
    t = 1'b0;
    for (int k = 0; k < 3000; k++) begin
      if ($urandom_range(0, 29) == 0) g = ~g;
      if ($urandom_range(0, 3) == 0) t = ~t;
      step(g, t);
      chk("rand.state", int'(state_o), m_state);
      chk("rand.level", int'(level_o), m_level);
      chk("rand.busy", int'(busy_o), (m_state != 0) ? 1 : 0);
      chk("rand.audio", int'(audio_o), m_audio);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
